// File: rtl/axi4_pkg.sv
// Shared AXI4 read-side types: burst and response encodings, the queued AR
// request record, and the read-responder FSM states.
package axi4_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 16;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } rd_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    burst_e                burst;
  } ar_req_t;

  // A burst is servable only as FIXED/INCR with beats no wider than the bus.
  function automatic logic burst_cfg_err(burst_e burst, logic [2:0] size,
                                         int unsigned byte_log2);
    return ((burst != FIXED) && (burst != INCR)) || (32'(size) > byte_log2);
  endfunction

endpackage

// File: rtl/ar_req_fifo.sv
// Count-based ring buffer of AR requests; the occupancy counter lets every
// slot be used, so full means count == depth.
module ar_req_fifo
  import axi4_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    push,
  input  ar_req_t din,
  input  logic    pop,
  output ar_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  ar_req_t               slots [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  always_comb begin
    full    = (count == CNT_MAX);
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = slots[rd_ptr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= din;
  end

endmodule

// File: rtl/axi4_rd_slave.sv
// AXI4 read responder: queues AR requests and streams FIXED/INCR bursts
// from a read-only word memory, with per-beat SLVERR/DECERR responses.
module axi4_rd_slave
  import axi4_pkg::*;
#(
  parameter int unsigned ID_W     = AXI_ID_W,
  parameter int unsigned ADDR_W   = AXI_ADDR_W,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MEM_LOG2 = 10,
  parameter int unsigned ARQ_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready
);

  localparam int unsigned BYTE_LOG2 = $clog2(DATA_W / 8);
  localparam logic [63:0] MEM_BYTES = 64'(1) << (MEM_LOG2 + BYTE_LOG2);

  ar_req_t   in_req;
  ar_req_t   head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      push;
  logic      pop;
  logic      load;
  logic      advance;

  rd_state_e         state_q;
  rd_state_e         state_d;
  logic [ID_W-1:0]   cur_id;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        beats_left;
  logic [2:0]        cur_size;
  burst_e            cur_burst;

  always_comb begin
    in_req = '{id:    AXI_ID_W'(arid),
               addr:  AXI_ADDR_W'(araddr),
               len:   arlen,
               size:  arsize,
               burst: burst_e'(arburst)};
    arready = !fifo_full;
    push    = arvalid && arready;
  end

  ar_req_fifo #(
    .DEPTH_LOG2 (ARQ_LOG2)
  ) u_arq (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (in_req),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The last-beat handshake pops the next request directly, so bursts
  // follow each other without an idle cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (rready) begin
          if (beats_left == 8'd0) begin
            if (!fifo_empty) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_id     <= '0;
      cur_addr   <= '0;
      beats_left <= '0;
      cur_size   <= '0;
      cur_burst  <= FIXED;
    end else if (load) begin
      cur_id     <= ID_W'(head.id);
      cur_addr   <= ADDR_W'(head.addr);
      beats_left <= head.len;
      cur_size   <= head.size;
      cur_burst  <= head.burst;
    end else if (advance) begin
      beats_left <= beats_left - 8'd1;
      if (cur_burst == INCR) cur_addr <= cur_addr + (ADDR_W'(1) << cur_size);
    end
  end

  // Word i of the preloaded read-only memory holds i, so the memory reduces
  // to returning the word index of the beat address.
  always_comb begin
    rvalid = (state_q == S_BURST);
    rid    = '0;
    rdata  = '0;
    rresp  = OKAY;
    rlast  = 1'b0;
    if (rvalid) begin
      rid   = cur_id;
      rlast = (beats_left == 8'd0);
      if (burst_cfg_err(cur_burst, cur_size, BYTE_LOG2)) begin
        rresp = SLVERR;
      end else if (64'(cur_addr) >= MEM_BYTES) begin
        rresp = DECERR;
      end else begin
        rdata = DATA_W'(cur_addr >> BYTE_LOG2);
      end
    end
  end

endmodule

// File: tb/tb_axi4_rd_slave.sv
// Directed and randomized checks of axi4_rd_slave against a beat-list model
// derived from the addressing and response rules.
module tb_axi4_rd_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  arid;
  logic [15:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  axi4_rd_slave #(
    .ID_W     (4),
    .ADDR_W   (16),
    .DATA_W   (32),
    .MEM_LOG2 (10),
    .ARQ_LOG2 (2)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  bit          ar_log[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected beats of one burst, computed per beat index from the start address.
  task automatic model_req(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    for (int unsigned b = 0; b <= 32'(len); b++) begin
      beat_t       e;
      int unsigned a;
      if (burst == 2'b01) a = (32'(addr) + b * (32'd1 << size)) % 32'd65536;
      else                a = 32'(addr);
      e.id   = id;
      e.last = (b == 32'(len));
      if (burst > 2'b01 || size > 3'd2) begin
        e.resp = 2'b10;
        e.data = 32'd0;
      end else if (a >= 32'd4096) begin
        e.resp = 2'b11;
        e.data = 32'd0;
      end else begin
        e.resp = 2'b00;
        e.data = a / 32'd4;
      end
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic try_ar(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst,
                        input int unsigned max_wait, output bit ok);
    arid    = id;
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arvalid = 1'b1;
    ok      = 1'b0;
    for (int unsigned w = 0; w <= max_wait; w++) begin
      if (arready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      model_req(id, addr, len, size, burst);
      @(negedge clk);
    end
    arvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    try_ar(id, addr, len, size, burst, 20, ok);
    check("ar_accept", 64'(ok), 64'd1);
  endtask

  // Drains exp_q from the R channel; contig demands rvalid every cycle once started.
  task automatic collect(input bit rand_rdy, input bit contig, input int unsigned max_cycles);
    int unsigned cyc     = 0;
    bit          started = 1'b0;
    ar_log.delete();
    while (exp_q.size() != 0 && cyc < max_cycles) begin
      rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      ar_log.push_back(arready);
      if (contig && started) check("no_bubble", 64'(rvalid), 64'd1);
      if (rvalid === 1'b1) begin
        started = 1'b1;
        check("rid",   64'(rid),   64'(exp_q[0].id));
        check("rdata", 64'(rdata), 64'(exp_q[0].data));
        check("rresp", 64'(rresp), 64'(exp_q[0].resp));
        check("rlast", 64'(rlast), 64'(exp_q[0].last));
        if (rready) void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    check("idle_after", 64'(rvalid), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    bit          ok;
    int unsigned n_acc;
    int unsigned waited;

    rstn    = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    arid    = '0;
    araddr  = '0;
    arlen   = '0;
    arsize  = '0;
    arburst = '0;
    repeat (2) @(negedge clk);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_rlast",   64'(rlast),   64'd0);
    check("rst_rid",     64'(rid),     64'd0);
    check("rst_rdata",   64'(rdata),   64'd0);
    check("rst_rresp",   64'(rresp),   64'd0);
    check("rst_arready", 64'(arready), 64'd1);
    rstn = 1'b1;
    @(negedge clk);

    // Single INCR with first-beat latency
    rready = 1'b1;
    do_ar(4'd5, 16'h0010, 8'd3, 3'd2, 2'b01);
    check("lat_edge1", 64'(rvalid), 64'd0);
    @(negedge clk);
    check("lat_edge2", 64'(rvalid), 64'd1);
    collect(1'b0, 1'b1, 50);

    do_ar(4'd1, 16'h0008, 8'd2, 3'd2, 2'b00);
    collect(1'b0, 1'b1, 50);

    do_ar(4'd2, 16'h0000, 8'd1, 3'd2, 2'b10);
    collect(1'b0, 1'b1, 50);
    do_ar(4'd3, 16'h0040, 8'd0, 3'd3, 2'b01);
    collect(1'b0, 1'b1, 50);

    do_ar(4'd4, 16'h0FFC, 8'd1, 3'd2, 2'b01);
    collect(1'b0, 1'b1, 50);

    // Backpressure: one burst stalled in flight, then fill the request queue
    rready = 1'b0;
    do_ar(4'd6, 16'h0020, 8'd1, 3'd2, 2'b01);
    waited = 0;
    while (rvalid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("stall_valid", 64'(rvalid), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("stall_rdata", 64'(rdata), 64'(exp_q[0].data));
      check("stall_rid",   64'(rid),   64'(exp_q[0].id));
    end
    n_acc = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      try_ar(4'(7 + i), 16'(32'h100 * (i + 1)), 8'(i % 3), 3'd2, 2'b01, 3, ok);
      if (ok) n_acc++;
    end
    check("fifo_capacity", 64'(n_acc), 64'd4);
    check("full_arready", 64'(arready), 64'd0);
    collect(1'b0, 1'b1, 200);
    check("arready_full",      64'(ar_log[0]), 64'd0);
    check("arready_mid_burst", 64'(ar_log[1]), 64'd0);
    check("arready_after_pop", 64'(ar_log[2]), 64'd1);

    // Asynchronous reset during beat 2 of 8 with a second request queued
    rready = 1'b1;
    do_ar(4'd9,  16'h0100, 8'd7, 3'd2, 2'b01);
    do_ar(4'd10, 16'h0200, 8'd0, 3'd2, 2'b01);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_rvalid", 64'(rvalid), 64'd1);
    check("pre_rst_rdata",  64'(rdata),  64'h42);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_rvalid",  64'(rvalid),  64'd0);
    check("mid_rst_arready", 64'(arready), 64'd1);
    check("mid_rst_rlast",   64'(rlast),   64'd0);
    check("mid_rst_rid",     64'(rid),     64'd0);
    check("mid_rst_rdata",   64'(rdata),   64'd0);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_ar(4'd11, 16'h0020, 8'd1, 3'd2, 2'b01);
    collect(1'b0, 1'b1, 50);

    // Randomized batches with random rready
    for (int unsigned batch = 0; batch < 8; batch++) begin
      int unsigned nb;
      nb     = $urandom_range(1, 4);
      rready = 1'b0;
      for (int unsigned k = 0; k < nb; k++) begin
        logic [15:0] a;
        int unsigned sel;
        int unsigned bsel;
        logic [1:0]  bt;
        sel = $urandom_range(0, 3);
        case (sel)
          0:       a = 16'($urandom_range(0, 4095));
          1:       a = 16'h0FF0 + 16'($urandom_range(0, 15));
          2:       a = 16'($urandom);
          default: a = 16'hFFF0 + 16'($urandom_range(0, 15));
        endcase
        bsel = $urandom_range(0, 5);
        bt   = (bsel < 2) ? 2'b00 : (bsel < 4) ? 2'b01 : 2'(bsel - 2);
        do_ar(4'($urandom), a, 8'($urandom_range(0, 7)), 3'($urandom_range(0, 3)), bt);
      end
      collect(1'b1, 1'b0, 3000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
